sd_block_reader: RTL and testbench

- Sits directly downstream of the SD card controller on its 180 MHz `clk`.
- Turns one client request ("read N blocks from address A") into N single-block read commands on the controller's command port.
- Captures each block's 16-bit `dataOut` words, which arrive with no backpressure, into an internal FIFO.
- Re-presents the words to the client on a valid/ready stream. A command is issued only when the FIFO has room for a whole block, so words are never dropped in normal operation.

---
 rtl/sd_defs.sv | 18 +
 rtl/sd_read_fifo.sv | 74 +++++++
 rtl/sd_block_reader.sv | 200 ++++++++++++++++++++
 tb/tb_sd_block_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_defs.sv
// rtl/sd_defs.sv - shared constants and FSM encoding for the SD block reader
package sd_defs;

  localparam int BLOCK_WORDS_DEFAULT = 256;

  // The reader only ever issues reads.
  localparam logic        CMD_WRITE_READ     = 1'b0;
  localparam logic [22:0] CMD_WRITE_LEN_NONE = 23'd0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROOM,
    ISSUE,
    RECV,
    ERR
  } readerStateT;

endpackage

// File: rtl/sd_read_fifo.sv
// rtl/sd_read_fifo.sv - synchronous FIFO with a registered head word
// The head register counts toward the level, so level never exceeds DEPTH.
module sd_read_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [LVL_W-1:0] memCount;
  logic [LVL_W-1:0] levelQ;
  logic             headValid;
  logic             headLoad;
  logic             bypass;
  logic             memRead;
  logic             memWrite;

  always_comb begin
    headLoad = !headValid || pop;
    // A push into an empty array goes straight to the head register.
    bypass   = push && headLoad && (memCount == '0);
    memRead  = headLoad && (memCount != '0);
    memWrite = push && !bypass;
  end

  always_ff @(posedge clk) begin
    if (memWrite) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      memCount  <= '0;
      levelQ    <= '0;
      headValid <= 1'b0;
      headData  <= '0;
    end else begin
      if (memWrite) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (memRead) begin
        headData <= mem[rdPtr];
        rdPtr    <= rdPtr + PTR_W'(1);
      end else if (bypass) begin
        headData <= pushData;
      end
      headValid <= memRead || bypass || (headValid && !pop);
      memCount  <= memCount + LVL_W'(memWrite) - LVL_W'(memRead);
      levelQ    <= levelQ + LVL_W'(push) - LVL_W'(pop);
    end
  end

  assign level = levelQ;
  assign full  = (levelQ == LVL_W'(DEPTH));
  assign empty = !headValid;

endmodule

// File: rtl/sd_block_reader.sv
// rtl/sd_block_reader.sv - splits a multi-block read into single-block SD commands
// Captured words are buffered and re-presented on a valid/ready stream.
module sd_block_reader
  import sd_defs::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
  parameter int FIFO_DEPTH  = 512,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_trigger,
  output logic               req_accepted,
  input  logic [31:0]        req_addr,
  input  logic [COUNT_W-1:0] req_count,
  output logic               busy,
  output logic               done,
  output logic               sd_cmd_trigger,
  input  logic               sd_cmd_accepted,
  output logic               sd_cmd_write,
  output logic [22:0]        sd_cmd_writeLen,
  output logic [31:0]        sd_cmd_addr,
  input  logic [15:0]        sd_dataOut,
  input  logic               sd_dataOut_valid,
  input  logic               sd_err,
  output logic [15:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_sd,
  output logic               err_protocol
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WC_W  = $clog2(BLOCK_WORDS);

  readerStateT        state;
  readerStateT        stateNext;
  logic [31:0]        addrQ;
  logic [COUNT_W-1:0] remainingQ;
  logic [WC_W-1:0]    wordCnt;
  logic               doneQ;
  logic               busyQ;
  logic               errSdQ;
  logic               errProtoQ;

  logic               accept;
  logic               cmdTrig;
  logic               cmdTaken;
  logic               fifoPush;
  logic               fifoPop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [LVL_W-1:0]   fifoLevel;
  logic               roomOk;
  logic               blockEnd;
  logic               stray;
  logic               overflow;

  sd_read_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pushData (sd_dataOut),
    .pop      (fifoPop),
    .headData (out_data),
    .level    (fifoLevel),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign out_valid = !fifoEmpty;
  assign fifoPop   = out_valid && out_ready;
  // Credit this cycle's pop so a draining client does not stall the next command.
  assign roomOk    = (LVL_W'(FIFO_DEPTH) - fifoLevel + LVL_W'(fifoPop)) >= LVL_W'(BLOCK_WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    cmdTrig   = 1'b0;
    cmdTaken  = 1'b0;
    fifoPush  = 1'b0;
    blockEnd  = 1'b0;
    stray     = 1'b0;
    overflow  = 1'b0;
    case (state)
      IDLE: begin
        accept = req_trigger && !busyQ && !rst;
        stray  = sd_dataOut_valid;
        if (accept && (req_count != '0)) begin
          stateNext = WAIT_ROOM;
        end
      end
      WAIT_ROOM: begin
        stray = sd_dataOut_valid;
        if (roomOk) begin
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        cmdTrig = 1'b1;
        stray   = sd_dataOut_valid;
        if (sd_cmd_accepted) begin
          cmdTaken  = 1'b1;
          stateNext = RECV;
        end
      end
      RECV: begin
        if (sd_dataOut_valid) begin
          if (fifoFull && !fifoPop) begin
            overflow  = 1'b1;
            stateNext = ERR;
          end else begin
            fifoPush = 1'b1;
            if (wordCnt == WC_W'(BLOCK_WORDS - 1)) begin
              blockEnd  = 1'b1;
              stateNext = (remainingQ == COUNT_W'(1)) ? IDLE : WAIT_ROOM;
            end
          end
        end
      end
      ERR: begin
        stray = sd_dataOut_valid;
      end
      default: stateNext = IDLE;
    endcase
    // A controller error wins over anything else happening this cycle.
    if (sd_err && (state != IDLE) && (state != ERR)) begin
      stateNext = ERR;
      cmdTrig   = 1'b0;
      cmdTaken  = 1'b0;
      fifoPush  = 1'b0;
      blockEnd  = 1'b0;
      overflow  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addrQ      <= '0;
      remainingQ <= '0;
      wordCnt    <= '0;
      doneQ      <= 1'b0;
      busyQ      <= 1'b0;
      errSdQ     <= 1'b0;
      errProtoQ  <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (doneQ) begin
        busyQ <= 1'b0;
      end
      if (accept) begin
        addrQ      <= req_addr;
        remainingQ <= req_count;
        busyQ      <= 1'b1;
        doneQ      <= (req_count == '0);
      end
      if (cmdTaken) begin
        wordCnt <= '0;
      end else if (fifoPush) begin
        wordCnt <= wordCnt + WC_W'(1);
      end
      if (blockEnd) begin
        addrQ      <= addrQ + 32'd1;
        remainingQ <= remainingQ - COUNT_W'(1);
        if (remainingQ == COUNT_W'(1)) begin
          doneQ <= 1'b1;
          busyQ <= 1'b0;
        end
      end
      if (sd_err && (state != IDLE)) begin
        errSdQ <= 1'b1;
      end
      if (stray || overflow) begin
        errProtoQ <= 1'b1;
      end
    end
  end

  assign req_accepted    = accept;
  assign busy            = busyQ;
  assign done            = doneQ;
  assign sd_cmd_trigger  = cmdTrig;
  assign sd_cmd_write    = CMD_WRITE_READ;
  assign sd_cmd_writeLen = CMD_WRITE_LEN_NONE;
  assign sd_cmd_addr     = addrQ;
  assign err_sd          = errSdQ;
  assign err_protocol    = errProtoQ;

endmodule

// File: tb/tb_sd_block_reader.sv
// tb/tb_sd_block_reader.sv - scoreboard bench with a behavioural SD controller model
module tb_sd_block_reader;

  localparam int BW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_trigger = 1'b0;
  logic        req_accepted;
  logic [31:0] req_addr = '0;
  logic [15:0] req_count = '0;
  logic        busy;
  logic        done;
  logic        sd_cmd_trigger;
  logic        sd_cmd_accepted = 1'b0;
  logic        sd_cmd_write;
  logic [22:0] sd_cmd_writeLen;
  logic [31:0] sd_cmd_addr;
  logic [15:0] sd_dataOut = '0;
  logic        sd_dataOut_valid;
  logic        sd_err = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_sd;
  logic        err_protocol;

  logic        ctrlValid = 1'b0;
  logic        strayValid = 1'b0;
  assign sd_dataOut_valid = ctrlValid | strayValid;

  int checks = 0, failures = 0;
  int cycleCnt = 0, expDoneAt = -1, doneSeen = 0;
  int popCnt = 0, popLimit = 0, blocksLeft = 0;
  int readyMode = 0, acceptDelay = 3, errAt = -1;
  bit seqData = 1'b1, gapsOn = 1'b0;
  logic [31:0] expCmd[$];
  logic [15:0] expWords[$];

  sd_block_reader dut (
    .clk              (clk),
    .rst              (rst),
    .req_trigger      (req_trigger),
    .req_accepted     (req_accepted),
    .req_addr         (req_addr),
    .req_count        (req_count),
    .busy             (busy),
    .done             (done),
    .sd_cmd_trigger   (sd_cmd_trigger),
    .sd_cmd_accepted  (sd_cmd_accepted),
    .sd_cmd_write     (sd_cmd_write),
    .sd_cmd_writeLen  (sd_cmd_writeLen),
    .sd_cmd_addr      (sd_cmd_addr),
    .sd_dataOut       (sd_dataOut),
    .sd_dataOut_valid (sd_dataOut_valid),
    .sd_err           (sd_err),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .err_sd           (err_sd),
    .err_protocol     (err_protocol)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Client side: readiness pattern selected by readyMode.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: out_ready = 1'b0;
      1: out_ready = ($urandom_range(3) != 0);
      2: out_ready = 1'b1;
      default: out_ready = (popCnt < popLimit);
    endcase
  end

  // Scoreboard: every consumed word must be the next one the controller sent.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      popCnt++;
      if (expWords.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL word_unexpected got=%0h exp=none", out_data);
      end else begin
        check("word_data", out_data, expWords.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done) doneSeen++;
      if (done || (cycleCnt == expDoneAt)) check("done_timing", done, (cycleCnt == expDoneAt));
    end
  end

  // Behavioural SD controller: accept each command after a delay, then stream one block.
  initial begin : controller
    int dly;
    forever begin
      @(negedge clk);
      if (!rst && sd_cmd_trigger) begin
        if (expCmd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cmd_unexpected got=%0h exp=none", sd_cmd_addr);
        end else begin
          check("cmd_addr", sd_cmd_addr, expCmd.pop_front());
        end
        check("cmd_write", {sd_cmd_write, sd_cmd_writeLen}, 0);
        dly = (acceptDelay > 0) ? acceptDelay : $urandom_range(1, 6);
        repeat (dly) @(posedge clk);
        #1 sd_cmd_accepted = 1'b1;
        @(posedge clk);
        #1 sd_cmd_accepted = 1'b0;
        for (int w = 0; w < BW; w++) begin
          if (gapsOn && ($urandom_range(3) == 0)) begin
            ctrlValid = 1'b0;
            @(posedge clk);
            #1;
          end
          if (w == errAt) begin
            ctrlValid = 1'b0;
            sd_err    = 1'b1;
            errAt     = -1;
            expCmd.delete();
            @(posedge clk);
            #1 sd_err = 1'b0;
            break;
          end
          sd_dataOut = seqData ? 16'(w) : 16'($urandom);
          ctrlValid  = 1'b1;
          expWords.push_back(sd_dataOut);
          if ((w == BW - 1) && (blocksLeft == 1)) expDoneAt = cycleCnt + 1;
          @(posedge clk);
          #1;
        end
        ctrlValid = 1'b0;
        blocksLeft--;
      end
    end
  end

  task automatic doReq(input logic [31:0] a, input int n, input bit expAcc);
    @(posedge clk);
    #1;
    req_addr    = a;
    req_count   = 16'(n);
    req_trigger = 1'b1;
    @(negedge clk);
    check("req_accepted", req_accepted, expAcc);
    if (expAcc) begin
      for (int i = 0; i < n; i++) expCmd.push_back(a + 32'(i));
      blocksLeft = n;
      if (n == 0) expDoneAt = cycleCnt + 1;
    end
    @(posedge clk);
    #1 req_trigger = 1'b0;
  endtask

  task automatic waitDrain(input int maxCyc, input string nm);
    int k = 0;
    while (!(expCmd.size() == 0 && expWords.size() == 0 && !busy) && k < maxCyc) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= maxCyc) begin
      failures++;
      $display("FAIL %s_timeout got=%0d cycles exp<%0d", nm, k, maxCyc);
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expCmd.delete();
    expWords.delete();
    expDoneAt  = -1;
    blocksLeft = 0;
    rst        = 1'b0;
  endtask

  initial begin : main
    int d0, p0, k;
    doReset();
    @(negedge clk);
    check("reset_outputs", {busy, done, out_valid, sd_cmd_trigger, err_sd, err_protocol, req_accepted}, 0);
    check("reset_data", {out_data, sd_cmd_addr}, 0);

    // Single block, sequential data, fixed accept delay.
    readyMode = 1;
    d0 = doneSeen;
    doReq(32'h100, 1, 1);
    waitDrain(3000, "single");
    check("single_done_count", doneSeen - d0, 1);

    // Backpressure: client stalls until two blocks fill the FIFO.
    seqData = 1'b0; gapsOn = 1'b1; acceptDelay = 0; readyMode = 0;
    d0 = doneSeen;
    doReq(32'h100, 3, 1);
    k = 0;
    while (!(expCmd.size() == 1 && expWords.size() == 512 && blocksLeft == 1) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("bp_two_blocks_in", (k < 4000), 1);
    repeat (40) @(negedge clk);
    check("bp_third_held", sd_cmd_trigger, 0);
    doReq(32'h999, 1, 0);
    check("bp_busy", busy, 1);
    popLimit = popCnt + 255;
    readyMode = 3;
    k = 0;
    while (popCnt < popLimit && k < 1000) begin
      @(negedge clk);
      k++;
    end
    readyMode = 0;
    repeat (20) @(negedge clk);
    check("bp_held_after_255_pops", sd_cmd_trigger, 0);
    readyMode = 1;
    waitDrain(6000, "bp");
    check("bp_done_count", doneSeen - d0, 1);
    check("bp_no_perr", err_protocol, 0);

    // Zero-count request: immediate done, no command.
    d0 = doneSeen;
    doReq(32'h500, 0, 1);
    @(negedge clk);
    @(negedge clk);
    check("zero_busy_drop", busy, 0);
    repeat (10) @(negedge clk);
    check("zero_done_count", doneSeen - d0, 1);

    // Address wrap across the 32-bit boundary.
    d0 = doneSeen;
    doReq(32'hFFFF_FFFF, 2, 1);
    waitDrain(6000, "wrap");
    check("wrap_done_count", doneSeen - d0, 1);

    // Controller error during word 100 of block 0.
    readyMode = 0; errAt = 100;
    d0 = doneSeen;
    doReq(32'h200, 2, 1);
    k = 0;
    while (!err_sd && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("err_sd_set", err_sd, 1);
    repeat (30) @(negedge clk);
    check("err_no_cmd", sd_cmd_trigger, 0);
    doReq(32'h300, 1, 0);
    p0 = popCnt;
    readyMode = 2;
    k = 0;
    while (out_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("err_drain_count", popCnt - p0, 100);
    check("err_no_done", doneSeen - d0, 0);
    check("err_flags", {err_sd, err_protocol}, 2'b10);
    doReset();
    @(negedge clk);
    check("err_reset_clears", {busy, out_valid, err_sd, err_protocol, sd_cmd_trigger}, 0);

    // Stray data word while idle.
    readyMode = 1;
    @(posedge clk);
    #1 strayValid = 1'b1;
    @(posedge clk);
    #1 strayValid = 1'b0;
    @(negedge clk);
    check("stray_perr", err_protocol, 1);
    check("stray_fifo_empty", out_valid, 0);
    d0 = doneSeen;
    doReq(32'h40, 1, 1);
    waitDrain(3000, "stray_follow");
    check("stray_follow_done", doneSeen - d0, 1);

    // Randomized requests.
    for (int r = 0; r < 4; r++) begin
      d0 = doneSeen;
      doReq($urandom, $urandom_range(1, 3), 1);
      waitDrain(8000, "rand");
      check("rand_done_count", doneSeen - d0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
